// File: rtl/updown_counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : updown_counter_sequencer
// Brief    : Sole bus master of the 8-bit up/down counter. It range-checks a host
//            configuration, writes PLR/ULR/LLR/CCR, pulses start and reports the
//            status. Macro READBACK_VERIFY_EN adds a read-back pass before start.
// Revision : 1.0
// ============================================================================
module updown_counter_sequencer #(
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_plr,
  input  logic [7:0] cfg_ulr,
  input  logic [7:0] cfg_llr,
  input  logic [7:0] cfg_ccr,
  output logic [7:0] bus_dout,
  output logic       bus_oe,
  input  logic [7:0] bus_din,
  output logic       ncs,
  output logic       nwr,
  output logic       nrd,
  output logic       A0,
  output logic       A1,
  output logic       start_out,
  input  logic       ec_in,
  input  logic       err_in,
  output logic       busy,
  output logic       done,
  output logic [2:0] status
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_CHECK     = 4'd1;
  localparam logic [3:0] S_WR_SETUP  = 4'd2;
  localparam logic [3:0] S_WR_STROBE = 4'd3;
  localparam logic [3:0] S_WR_HOLD   = 4'd4;
  localparam logic [3:0] S_START     = 4'd5;
  localparam logic [3:0] S_WAIT_END  = 4'd6;
  localparam logic [3:0] S_DONE      = 4'd7;
  localparam logic [3:0] S_FAIL      = 4'd8;
`ifdef READBACK_VERIFY_EN
  localparam logic [3:0] S_RD_SETUP  = 4'd9;
  localparam logic [3:0] S_RD_STROBE = 4'd10;
  localparam logic [3:0] S_RD_HOLD   = 4'd11;
  localparam logic [2:0] ST_ERR_VERIFY = 3'd4;
`endif

  localparam logic [2:0] ST_OK        = 3'd0;
  localparam logic [2:0] ST_ERR_RANGE = 3'd1;
  localparam logic [2:0] ST_ERR_DEV   = 3'd2;
  localparam logic [2:0] ST_TIMEOUT   = 3'd3;

  localparam logic [7:0]  c_setup_last  = 8'(SETUP_CYC - 1);
  localparam logic [7:0]  c_strobe_last = 8'(STROBE_CYC - 1);
  localparam logic [15:0] c_tmo_last    = 16'(TIMEOUT_CYC - 1);

  logic [3:0]  r_state;
  logic [3:0]  w_next;
  logic [2:0]  w_fail_code;
  logic [7:0]  r_cfg [4];     // indexed in write order: PLR, ULR, LLR, CCR
  logic [1:0]  r_idx;
  logic [7:0]  r_phase;
  logic [15:0] r_tmo;
  logic [2:0]  r_status;
  logic        w_accept;
  logic        w_range_bad;

  assign w_accept    = cfg_valid && cfg_ready;
  assign w_range_bad = (r_cfg[2] > r_cfg[1]) || (r_cfg[0] < r_cfg[2]) || (r_cfg[0] > r_cfg[1]);
  assign status      = r_status;

`ifdef READBACK_VERIFY_EN
  logic r_mismatch;
`else
  logic w_unused_din;
  assign w_unused_din = ^bus_din;
`endif

  always_ff @(posedge clk_in) begin
    if (reset_in) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      for (int k = 0; k < 4; k++) r_cfg[k] <= 8'd0;
      r_idx    <= 2'd0;
      r_phase  <= 8'd0;
      r_tmo    <= 16'd0;
      r_status <= ST_OK;
`ifdef READBACK_VERIFY_EN
      r_mismatch <= 1'b0;
`endif
    end else begin
      // Phase counter restarts on every state change; it times setup/strobe.
      r_phase <= (w_next == r_state) ? r_phase + 8'd1 : 8'd0;
      if (w_accept) begin
        r_cfg[0] <= cfg_plr;
        r_cfg[1] <= cfg_ulr;
        r_cfg[2] <= cfg_llr;
        r_cfg[3] <= cfg_ccr;
        r_status <= ST_OK;
      end
      if (r_state == S_CHECK)
        r_idx <= 2'd0;
      else if (w_next == S_WR_SETUP && r_state == S_WR_HOLD)
        r_idx <= r_idx + 2'd1;
`ifdef READBACK_VERIFY_EN
      // Index wraps 3 -> 0 when leaving the last write, ready for read-back.
      else if (r_state == S_WR_HOLD || (r_state == S_RD_HOLD && w_next == S_RD_SETUP))
        r_idx <= r_idx + 2'd1;
      if (r_state == S_CHECK)
        r_mismatch <= 1'b0;
      else if (r_state == S_RD_STROBE && r_phase == c_strobe_last)
        r_mismatch <= (bus_din != r_cfg[r_idx]);
`endif
      if (r_state == S_START)         r_tmo <= 16'd0;
      else if (r_state == S_WAIT_END) r_tmo <= r_tmo + 16'd1;
      if (w_next == S_FAIL) r_status <= w_fail_code;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_fail_code = ST_OK;
    case (r_state)
      S_IDLE:      if (cfg_valid) w_next = S_CHECK;
      S_CHECK:
        if (w_range_bad) begin
          w_next      = S_FAIL;
          w_fail_code = ST_ERR_RANGE;
        end else begin
          w_next = S_WR_SETUP;
        end
      S_WR_SETUP:  if (r_phase == c_setup_last)  w_next = S_WR_STROBE;
      S_WR_STROBE: if (r_phase == c_strobe_last) w_next = S_WR_HOLD;
      S_WR_HOLD:
        if (r_idx != 2'd3) w_next = S_WR_SETUP;
`ifdef READBACK_VERIFY_EN
        else               w_next = S_RD_SETUP;
      S_RD_SETUP:  if (r_phase == c_setup_last)  w_next = S_RD_STROBE;
      S_RD_STROBE: if (r_phase == c_strobe_last) w_next = S_RD_HOLD;
      S_RD_HOLD:
        if (r_mismatch) begin
          w_next      = S_FAIL;
          w_fail_code = ST_ERR_VERIFY;
        end else if (r_idx != 2'd3) begin
          w_next = S_RD_SETUP;
        end else begin
          w_next = S_START;
        end
`else
        else               w_next = S_START;
`endif
      S_START:     w_next = S_WAIT_END;
      S_WAIT_END:
        if (err_in) begin
          w_next      = S_FAIL;
          w_fail_code = ST_ERR_DEV;
        end else if (ec_in) begin
          w_next = S_DONE;
        end else if (r_tmo == c_tmo_last) begin
          w_next      = S_FAIL;
          w_fail_code = ST_TIMEOUT;
        end
      S_DONE, S_FAIL: w_next = S_IDLE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (r_state == S_IDLE);
    busy      = (r_state != S_IDLE);
    ncs       = 1'b1;
    nwr       = 1'b1;
    nrd       = 1'b1;
    bus_oe    = 1'b0;
    bus_dout  = 8'd0;
    A0        = 1'b0;
    A1        = 1'b0;
    start_out = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_WR_SETUP, S_WR_STROBE, S_WR_HOLD: begin
        ncs      = 1'b0;
        bus_oe   = 1'b1;
        bus_dout = r_cfg[r_idx];
        A0       = r_idx[1];
        A1       = r_idx[0];
        nwr      = (r_state != S_WR_STROBE);
      end
`ifdef READBACK_VERIFY_EN
      S_RD_SETUP, S_RD_STROBE, S_RD_HOLD: begin
        ncs = 1'b0;
        A0  = r_idx[1];
        A1  = r_idx[0];
        nrd = (r_state != S_RD_STROBE);
      end
`endif
      S_START: begin
        ncs       = 1'b0;
        start_out = 1'b1;
      end
      S_WAIT_END:     ncs  = 1'b0;
      S_DONE, S_FAIL: done = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_updown_counter_sequencer
// Brief    : Scoreboard bench: expected bus writes and statuses are queued at
//            accept time and popped as the sequencer produces them.
// Revision : 1.0
// ============================================================================
module tb_updown_counter_sequencer;

  localparam int TMO = 32;
`ifdef READBACK_VERIFY_EN
  localparam int RDX = 16;
`else
  localparam int RDX = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_in, cfg_valid, cfg_ready;
  logic [7:0] cfg_plr, cfg_ulr, cfg_llr, cfg_ccr;
  logic [7:0] bus_dout, bus_din;
  logic       bus_oe, ncs, nwr, nrd, A0, A1, start_out;
  logic       ec_in, err_in, busy, done;
  logic [2:0] status;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_start = 0;
  int         start_cyc = 0;
  int         acc = 0;
  bit         ncs_low_seen = 1'b0;
  bit         prev_nwr = 1'b1;
  bit         corrupt = 1'b0;
  logic [7:0] rb_mem [4];
  logic [9:0] exp_wr [$];
  logic [2:0] exp_st [$];
  logic [9:0] mon_w;

  updown_counter_sequencer #(.SETUP_CYC(1), .STROBE_CYC(2), .TIMEOUT_CYC(TMO)) dut (
    .clk_in(clk), .reset_in(reset_in), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_plr(cfg_plr), .cfg_ulr(cfg_ulr), .cfg_llr(cfg_llr), .cfg_ccr(cfg_ccr),
    .bus_dout(bus_dout), .bus_oe(bus_oe), .bus_din(bus_din),
    .ncs(ncs), .nwr(nwr), .nrd(nrd), .A0(A0), .A1(A1), .start_out(start_out),
    .ec_in(ec_in), .err_in(err_in), .busy(busy), .done(done), .status(status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Counter register file model; ULR can be corrupted on read.
  assign bus_din = rb_mem[{A0, A1}] + {7'd0, (corrupt && ({A0, A1} == 2'b01))};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!ncs) ncs_low_seen = 1'b1;
    if (start_out) begin
      n_start++;
      start_cyc = cyc;
    end
    if (!ncs) check("strobe_excl", {31'd0, (!nwr && !nrd)}, 0);
    if (!nwr && prev_nwr) begin
      rb_mem[{A0, A1}] = bus_dout;
      if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        mon_w = exp_wr.pop_front();
        check("wr_addr", {30'd0, A0, A1}, {30'd0, mon_w[9:8]});
        check("wr_data", {24'd0, bus_dout}, {24'd0, mon_w[7:0]});
        check("wr_oe", {31'd0, bus_oe}, 1);
      end
    end
    if (done) begin
      if (exp_st.size() == 0) check("done_unexpected", 1, 0);
      else check("status", {29'd0, status}, {29'd0, exp_st.pop_front()});
    end
    prev_nwr = nwr;
  end

  task automatic send(input logic [7:0] p, input logic [7:0] u, input logic [7:0] l,
                      input logic [7:0] c);
    int b;
    @(negedge clk);
    cfg_plr = p; cfg_ulr = u; cfg_llr = l; cfg_ccr = c; cfg_valid = 1'b1;
    b = 0;
    while (!cfg_ready && b < 100) begin
      @(negedge clk);
      b++;
    end
    check("cfg_ready_wait", {31'd0, cfg_ready}, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    acc = cyc;
    if (!(l > u || p < l || p > u)) begin
      exp_wr.push_back({2'd0, p});
      exp_wr.push_back({2'd1, u});
      exp_wr.push_back({2'd2, l});
      exp_wr.push_back({2'd3, c});
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Single-cycle ec/err pulses are cleared here on the following negedge.
  task automatic wait_done(output int dc);
    int b;
    b = 0;
    dc = -1;
    while (b < 300) begin
      @(negedge clk);
      ec_in = 1'b0;
      err_in = 1'b0;
      if (done) begin
        dc = cyc;
        break;
      end
      b++;
    end
    if (dc < 0) check("done_seen", 0, 1);
  endtask

  initial begin
    int dc, s0;
    for (int k = 0; k < 4; k++) rb_mem[k] = 8'd0;
    reset_in = 1'b1; cfg_valid = 1'b0; ec_in = 1'b0; err_in = 1'b0;
    cfg_plr = 8'd0; cfg_ulr = 8'd0; cfg_llr = 8'd0; cfg_ccr = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {24'd0, ncs, nwr, nrd, bus_oe, A0, A1, start_out, done}, 32'h000000E0);
    check("rst_hs", {30'd0, cfg_ready, busy}, 2);
    check("rst_dout", {24'd0, bus_dout}, 0);
    check("rst_status", {29'd0, status}, 0);
    reset_in = 1'b0;

    // Normal run; stray ec during the writes must be ignored.
    s0 = n_start;
    send(8'd10, 8'd20, 8'd5, 8'd2);
    exp_st.push_back(3'd0);
    wait_until(acc + 5);
    ec_in = 1'b1;
    @(negedge clk);
    ec_in = 1'b0;
    wait_until(acc + 39);
    ec_in = 1'b1;
    wait_done(dc);
    // start_out is sampled by the counter on edge acc+18
    check("t1_start_ofs", start_cyc - acc, 17 + RDX);
    check("t1_start_cnt", n_start - s0, 1);
    check("t1_done_ofs", dc - acc, 40);
    @(negedge clk);
    check("t1_idle", {29'd0, cfg_ready, busy, done}, 4);

    // Range errors: plr>ulr, plr<llr, llr>ulr.
    ncs_low_seen = 1'b0;
    send(8'd30, 8'd20, 8'd5, 8'd9);
    exp_st.push_back(3'd1);
    wait_done(dc);
    check("t2_done_ofs", dc - acc, 1);
    @(negedge clk);
    check("t2_ready", {31'd0, cfg_ready}, 1);
    send(8'd4, 8'd20, 8'd5, 8'd9);
    exp_st.push_back(3'd1);
    wait_done(dc);
    send(8'd10, 8'd4, 8'd5, 8'd9);
    exp_st.push_back(3'd1);
    wait_done(dc);
    check("t2_no_bus", {31'd0, ncs_low_seen}, 0);

    // err and ec together: err wins.
    send(8'd10, 8'd20, 8'd5, 8'd3);
    exp_st.push_back(3'd2);
    wait_until(acc + 18 + RDX);
    err_in = 1'b1;
    ec_in = 1'b1;
    wait_done(dc);
    check("t3_done_ofs", dc - acc, 19 + RDX);

    // Timeout.
    send(8'd10, 8'd20, 8'd5, 8'd3);
    exp_st.push_back(3'd3);
    wait_done(dc);
    check("t4_tmo_ofs", dc - (start_cyc + 1), TMO);

    // CCR=0 with equal bounds, immediate end-of-count.
    s0 = n_start;
    send(8'd7, 8'd7, 8'd7, 8'd0);
    exp_st.push_back(3'd0);
    wait_until(acc + 18 + RDX);
    ec_in = 1'b1;
    wait_done(dc);
    check("t5_done_ofs", dc - acc, 19 + RDX);
    check("t5_start_cnt", n_start - s0, 1);

    // Reset during the ULR strobe.
    send(8'd10, 8'd20, 8'd5, 8'd2);
    wait_until(acc + 6);
    check("t6_ulr_strobe", {30'd0, nwr, A1}, 1);
    reset_in = 1'b1;
    @(negedge clk);
    check("t6_rst_bus", {28'd0, ncs, nwr, bus_oe, cfg_ready}, 32'hD);
    reset_in = 1'b0;
    ncs_low_seen = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_quiet", {31'd0, ncs_low_seen}, 0);
    check("t6_wr_left", exp_wr.size(), 2);
    exp_wr.delete();

`ifdef READBACK_VERIFY_EN
    // Read-back mismatch on ULR.
    s0 = n_start;
    corrupt = 1'b1;
    send(8'd10, 8'd20, 8'd5, 8'd2);
    exp_st.push_back(3'd4);
    wait_done(dc);
    check("t7_done_ofs", dc - acc, 25);
    check("t7_no_start", n_start - s0, 0);
    corrupt = 1'b0;
`endif

    repeat (2) @(negedge clk);
    check("wr_queue_empty", exp_wr.size(), 0);
    check("st_queue_empty", exp_st.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/updown_counter_sequencer.md
Name: updown_counter_sequencer

Overview:
Sequences one complete run of the 8-bit up/down counter block over that block's bus.
- Accepts a configuration (PLR, ULR, LLR, CCR) from a host via valid/ready.
- Range-checks the configuration.
- Writes the four registers through ncs/nwr/A0/A1/data, then pulses start.
- Waits for end-of-count or error and reports a completion status.
- Sits between the host/CPU interface and the counter; it is the counter's only bus master.

Parameters:
SETUP_CYC, 1, cycles address/data are driven with nwr/nrd high before the strobe (>=1)
STROBE_CYC, 2, cycles nwr (or nrd) is held low (>=1)
TIMEOUT_CYC, 4096, max cycles in WAIT_END before timeout (16-bit counter, >=1)

Ports:
clk_in  input  1  clock, all logic on rising edge
reset_in  input  1  synchronous reset, active-high
cfg_valid  input  1  host presents a configuration
cfg_ready  output  1  sequencer can accept a configuration
cfg_plr / cfg_ulr / cfg_llr / cfg_ccr  input  8 each  preload, upper limit, lower limit, cycle count
bus_dout  output  8  write data to counter data bus
bus_oe  output  1  1 = sequencer drives the data bus
bus_din  input  8  read data from counter data bus (used only with the optional feature)
ncs / nwr / nrd  output  1 each  chip select, write strobe, read strobe (active-low)
A0 / A1  output  1 each  register select: {A0,A1} = 00 PLR, 01 ULR, 10 LLR, 11 CCR
start_out  output  1  one-cycle start pulse to counter
ec_in / err_in  input  1 each  end-count and error from counter
busy  output  1  high whenever not in IDLE
done  output  1  one-cycle pulse at completion (success or failure)
status  output  3  0 OK, 1 ERR_RANGE, 2 ERR_DEV, 3 TIMEOUT, 4 ERR_VERIFY; held until next accept

Behaviour:
- Reset (reset_in=1 at an edge): the following hold from the next cycle.
  - ncs=nwr=nrd=1, bus_oe=0, bus_dout=0, A0=A1=0.
  - start_out=0, cfg_ready=1, busy=0, done=0, status=0.
  - FSM goes to IDLE.
  - Reset mid-transaction aborts immediately; no write completes after reset is seen.
- Handshake:
  - cfg_ready=1 only in IDLE.
  - Transfer occurs on an edge with cfg_valid&&cfg_ready. All four values are captured and status clears to 0.
  - cfg_valid while not ready is ignored; the host holds it.
- States:
  - IDLE: wait for transfer, then go to CHECK.
  - CHECK (1 cycle):
    - If llr>ulr, plr<llr or plr>ulr: go to FAIL with status=1. No bus activity occurs.
    - Otherwise set index i=0 and go to WR_SETUP.
  - WR_SETUP (SETUP_CYC cycles): ncs=0, bus_oe=1, bus_dout=reg[i], A0=i[1], A1=i[0], nwr=1.
  - WR_STROBE (STROBE_CYC cycles): as WR_SETUP, with nwr=0.
  - WR_HOLD (1 cycle): nwr=1, with data, address and oe still held.
    - If i<3: i++ and go to WR_SETUP.
    - Else go to START (or RD_SETUP with the optional feature).
  - START (1 cycle): ncs=0, bus_oe=0, start_out=1. Clear the timeout counter.
  - WAIT_END: ncs=0, bus idle. Evaluated in this priority order:
    - err_in=1: go to FAIL, status=2.
    - else ec_in=1: go to DONE, status=0.
    - else counter==TIMEOUT_CYC-1: go to FAIL, status=3.
    - else increment counter.
  - DONE / FAIL (1 cycle): done=1, ncs=1, bus_oe=0, then return to IDLE.
- Write order is fixed: PLR, ULR, LLR, CCR.
  - Each write lasts SETUP_CYC+STROBE_CYC+1 cycles, 4 with defaults.
  - With defaults, start_out rises 18 cycles after the accept edge (1 CHECK + 16 write cycles + 1).
- CCR=0 is legal: it is written and started, and the counter's immediate ec_in completes the run.
- bus_oe is never 1 while nrd=0; nwr and nrd are never both 0.
- ec_in/err_in are ignored outside WAIT_END.

Optional Feature:
Macro: READBACK_VERIFY_EN.
- Defined:
  - After the CCR write, each of i=0..3 is read back.
  - RD_SETUP runs SETUP_CYC cycles with bus_oe=0, ncs=0 and the address set.
  - RD_STROBE runs STROBE_CYC cycles with nrd=0. bus_din is sampled on the last strobe cycle.
  - RD_HOLD runs 1 cycle.
  - Any mismatch with the captured value goes to FAIL with status=4 and start is not issued. Otherwise go to START.
  - start_out is delayed by a further 16 cycles with defaults.
- Undefined: the read states are absent, bus_din is unused, and the flow goes WR_HOLD(i=3) -> START.

Test Plan:
1. Accept PLR=10, ULR=20, LLR=5, CCR=2 -> four writes in order on A0A1=00,01,10,11 with bus_dout 10,20,5,2. nwr low 2 cycles each. start_out at accept+18. ec_in at +40 gives done=1, status=0.
2. Accept PLR=30, ULR=20, LLR=5 -> done at accept+2 with status=1. ncs stays 1 throughout and cfg_ready returns to 1.
3. Valid config, err_in and ec_in asserted in the same WAIT_END cycle -> status=2, done pulse next cycle.
4. TIMEOUT_CYC=8, no ec_in -> status=3 with done exactly 8 cycles after leaving START.
5. reset_in asserted during the ULR write strobe -> next cycle ncs=nwr=1, bus_oe=0, cfg_ready=1, and no further bus activity.
6. READBACK_VERIFY_EN defined, bus_din returns 21 for ULR=20 -> status=4 and start_out never asserted.
